// File: rtl/maze_collision_fsm_pkg.sv
// Shared definitions for the maze collision controller.
//   state_t          game state encoding, visible on the top-level state port
//   in_span()        11-bit window membership test used by the cursor accumulator
//   *_DEF            default parameter values for the top and the accumulator
package maze_collision_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int CURSOR_SIZE_DEF  = 8;
  localparam int NUM_LEVELS_DEF   = 3;
  localparam int ARM_FRAMES_DEF   = 4;
  localparam int SCARE_FRAMES_DEF = 120;

  // 11 bits so a window starting near 1023 cannot wrap back to column 0.
  function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                   input int size);
    logic [10:0] hi;
    hi = lo + 11'(size - 1);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/maze_collision_fsm_hit_accum.sv
// Cursor window hit accumulator.
// Latches the cursor position at each frame start and, for the rest of that
// frame, ORs together what the visible pixels under the cursor square show.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   pixel_tick, video_on          pixel strobe and visible-area flag
//   frame_tick                    frame start pulse; latches cursor, restarts accumulation
//   pix_x, pix_y                  current pixel coordinates
//   cur_x, cur_y                  cursor top-left, sampled on frame_tick
//   path_on, goal_on              maze path / goal flags for the current pixel
//   seen, wall, goal              accumulated flags of the frame in progress; on the
//                                 frame_tick clk they describe the frame just finished
module maze_collision_fsm_hit_accum
  import maze_collision_fsm_pkg::*;
#(
  parameter int CURSOR_SIZE = CURSOR_SIZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic       path_on,
  input  logic       goal_on,
  output logic       seen,
  output logic       wall,
  output logic       goal
);

  logic [9:0] win_x, win_y;
  logic [9:0] use_x, use_y;
  logic       hit;

  // A pixel arriving with frame_tick belongs to the new frame, so it is
  // judged against the cursor position being latched on that same clk.
  assign use_x = frame_tick ? cur_x : win_x;
  assign use_y = frame_tick ? cur_y : win_y;

  assign hit = pixel_tick && video_on &&
               in_span({1'b0, pix_x}, {1'b0, use_x}, CURSOR_SIZE) &&
               in_span({1'b0, pix_y}, {1'b0, use_y}, CURSOR_SIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_x <= '0;
      win_y <= '0;
      seen  <= 1'b0;
      wall  <= 1'b0;
      goal  <= 1'b0;
    end else if (frame_tick) begin
      win_x <= cur_x;
      win_y <= cur_y;
      seen  <= hit;
      wall  <= hit && !path_on;
      goal  <= hit && goal_on;
    end else if (hit) begin
      seen <= 1'b1;
      wall <= wall | !path_on;
      goal <= goal | goal_on;
    end
  end

endmodule

// File: rtl/maze_collision_fsm.sv
// Maze game level/collision controller.
// Judges each finished frame from the cursor accumulator and steps the game
// state machine on frame_tick. All outputs are registered.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pixel_tick, video_on       pixel strobe, visible-area flag
//   frame_tick                 one-clk pulse at frame start
//   pix_x, pix_y               current pixel coordinates
//   cur_x, cur_y               cursor top-left, sampled on frame_tick
//   path_on, goal_on           maze path / goal flags of current pixel
//   start                      debounced player start, level-sensitive
//   state                      game state (see table)
//   level                      active level index
//   level_up                   one-clk pulse on level advance
//   scare                      one-clk pulse on entry to LOSE
//   game_done                  high while in DONE
//
// state | meaning
// IDLE  | waiting for start
// ARM   | counting consecutive clean frames before play
// PLAY  | live: wall loses, goal wins
// WIN   | one frame of level completion
// LOSE  | scare hold for SCARE_FRAMES frames
// DONE  | all levels cleared, waiting for a fresh start press
module maze_collision_fsm
  import maze_collision_fsm_pkg::*;
#(
  parameter int CURSOR_SIZE  = CURSOR_SIZE_DEF,
  parameter int NUM_LEVELS   = NUM_LEVELS_DEF,
  parameter int ARM_FRAMES   = ARM_FRAMES_DEF,
  parameter int SCARE_FRAMES = SCARE_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic       path_on,
  input  logic       goal_on,
  input  logic       start,
  output logic [2:0] state,
  output logic [1:0] level,
  output logic       level_up,
  output logic       scare,
  output logic       game_done
);

  localparam int ARM_W  = $clog2(ARM_FRAMES + 1);
  localparam int HOLD_W = $clog2(SCARE_FRAMES + 1);
  localparam logic [ARM_W-1:0]  ARM_LAST   = ARM_W'(ARM_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(SCARE_FRAMES - 1);
  localparam logic [1:0]        LEVEL_LAST = 2'(NUM_LEVELS - 1);

  state_t            st;
  logic [ARM_W-1:0]  arm_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_d, rise_pend, start_rise;
  logic              seen, wall, goal, frame_wall;

  maze_collision_fsm_hit_accum #(.CURSOR_SIZE(CURSOR_SIZE)) u_accum (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .path_on    (path_on),
    .goal_on    (goal_on),
    .seen       (seen),
    .wall       (wall),
    .goal       (goal)
  );

  // A frame in which the cursor showed no visible pixel at all is treated as
  // a wall hit, so a cursor parked off-screen can never arm or win.
  assign frame_wall = !seen || wall;
  assign start_rise = start && !start_d;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      level     <= '0;
      level_up  <= 1'b0;
      scare     <= 1'b0;
      game_done <= 1'b0;
      arm_cnt   <= '0;
      hold_cnt  <= '0;
      start_d   <= 1'b0;
      rise_pend <= 1'b0;
    end else begin
      level_up <= 1'b0;
      scare    <= 1'b0;
      start_d  <= start;
      // A start press may land between frame ticks; remember it until the
      // next tick so DONE can leave on it.
      rise_pend <= (st == S_DONE) ? (rise_pend | start_rise) : 1'b0;
      case (st)
        S_IDLE: begin
          if (frame_tick && start) begin
            st      <= S_ARM;
            arm_cnt <= '0;
          end
        end
        S_ARM: begin
          if (frame_tick) begin
            if (!start) begin
              st <= S_IDLE;
            end else if (frame_wall) begin
              arm_cnt <= '0;
            end else if (arm_cnt == ARM_LAST) begin
              st      <= S_PLAY;
              arm_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (frame_wall) begin
              st       <= S_LOSE;
              scare    <= 1'b1;
              hold_cnt <= '0;
            end else if (goal) begin
              st <= S_WIN;
            end
          end
        end
        S_WIN: begin
          if (frame_tick) begin
            if (level == LEVEL_LAST) begin
              st        <= S_DONE;
              game_done <= 1'b1;
            end else begin
              st       <= S_ARM;
              level    <= level + 1'b1;
              level_up <= 1'b1;
              arm_cnt  <= '0;
            end
          end
        end
        S_LOSE: begin
          if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              st       <= S_IDLE;
              level    <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (frame_tick && (rise_pend || start_rise)) begin
            st        <= S_IDLE;
            level     <= '0;
            game_done <= 1'b0;
          end
        end
        default: begin
          st        <= S_IDLE;
          game_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_collision_fsm.sv
// Randomized bench for maze_collision_fsm against a frame-level game model.
module tb_maze_collision_fsm;

  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_WIN = 3, M_LOSE = 4, M_DONE = 5;

  logic       clk = 1'b0;
  logic       reset, pixel_tick, video_on, frame_tick, path_on, goal_on, start;
  logic [9:0] pix_x, pix_y, cur_x, cur_y;
  logic [2:0] state;
  logic [1:0] level;
  logic       level_up, scare, game_done;

  always #5 clk = ~clk;

  maze_collision_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .path_on    (path_on),
    .goal_on    (goal_on),
    .start      (start),
    .state      (state),
    .level      (level),
    .level_up   (level_up),
    .scare      (scare),
    .game_done  (game_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: game rules applied to whole-frame verdicts.
  int m_state, m_level, m_arm, m_hold, m_wx, m_wy;
  bit m_up, m_scare, m_done, m_seen, m_wall, m_goal, m_start_d, m_rise;
  int n_lose = 0, n_win = 0, n_done = 0, n_play = 0;

  task automatic model_edge();
    bit rise, wall_v, hit;
    int wx, wy, px, py, old;
    if (reset) begin
      m_state = M_IDLE; m_level = 0; m_arm = 0; m_hold = 0; m_wx = 0; m_wy = 0;
      m_up = 0; m_scare = 0; m_done = 0; m_seen = 0; m_wall = 0; m_goal = 0;
      m_start_d = 0; m_rise = 0;
      return;
    end
    rise = start && !m_start_d;
    m_up = 0; m_scare = 0;
    old = m_state;
    wx = frame_tick ? int'(cur_x) : m_wx;
    wy = frame_tick ? int'(cur_y) : m_wy;
    px = int'(pix_x); py = int'(pix_y);
    hit = pixel_tick && video_on && px >= wx && px < wx + 8 && py >= wy && py < wy + 8;
    if (frame_tick) begin
      wall_v = !m_seen || m_wall;
      case (m_state)
        M_IDLE: if (start) begin m_state = M_ARM; m_arm = 0; end
        M_ARM: begin
          if (!start) m_state = M_IDLE;
          else if (wall_v) m_arm = 0;
          else begin
            m_arm++;
            if (m_arm == 4) begin m_state = M_PLAY; m_arm = 0; n_play++; end
          end
        end
        M_PLAY: begin
          if (wall_v) begin m_state = M_LOSE; m_scare = 1; m_hold = 0; n_lose++; end
          else if (m_goal) begin m_state = M_WIN; n_win++; end
        end
        M_WIN: begin
          if (m_level == 2) begin m_state = M_DONE; n_done++; end
          else begin m_level++; m_up = 1; m_state = M_ARM; m_arm = 0; end
        end
        M_LOSE: begin
          m_hold++;
          if (m_hold == 120) begin m_state = M_IDLE; m_level = 0; end
        end
        M_DONE: if (m_rise || rise) begin m_state = M_IDLE; m_level = 0; end
        default: m_state = M_IDLE;
      endcase
      m_seen = 0; m_wall = 0; m_goal = 0;
      m_wx = int'(cur_x); m_wy = int'(cur_y);
    end
    if (hit) begin
      m_seen = 1;
      if (!path_on) m_wall = 1;
      if (goal_on) m_goal = 1;
    end
    m_rise = (old == M_DONE) ? (m_rise || rise) : 1'b0;
    m_start_d = start;
    m_done = (m_state == M_DONE);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("state", int'(state), m_state);
    check("level", int'(level), m_level);
    check("level_up", int'(level_up), int'(m_up));
    check("scare", int'(scare), int'(m_scare));
    check("game_done", int'(game_done), int'(m_done));
  endtask

  // mode: 0 clean, 1 goal, 2 wall, 3 wall+goal, 4 empty (cursor pixels never shown)
  task automatic run_frame();
    int wx, wy, r, mode, px, py;
    wx = ($urandom_range(0, 7) == 0) ? 632 + $urandom_range(0, 7) : $urandom_range(0, 639);
    wy = ($urandom_range(0, 9) == 0) ? 472 + $urandom_range(0, 7) : $urandom_range(0, 479);
    cur_x = 10'(wx); cur_y = 10'(wy);
    if (m_state == M_DONE) start = 1'($urandom_range(0, 1));
    else start = ($urandom_range(0, 19) != 0);
    r = $urandom_range(0, 19);
    if (m_state == M_PLAY)
      mode = (r < 8) ? 1 : (r < 10) ? 2 : (r < 11) ? 3 : (r < 12) ? 4 : 0;
    else
      mode = (r < 2) ? 1 : (r < 5) ? 2 : (r < 6) ? 3 : (r < 7) ? 4 : 0;

    frame_tick = 1; pixel_tick = 1; video_on = 1; pix_x = 0; pix_y = 0;
    path_on = 1'($urandom_range(0, 1)); goal_on = 0;
    tick();
    frame_tick = 0;
    cur_x = 10'($urandom_range(0, 639)); cur_y = 10'($urandom_range(0, 479));

    for (int i = 0; i < 7; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      pixel_tick = (i != 3);
      goal_on = 0;
      if (mode == 4 || i == 5) begin
        px = (wx + 8 + $urandom_range(0, 31)) % 640;
        py = wy;
        path_on = 0;
        video_on = 1;
      end else begin
        px = (i == 0) ? wx : wx + $urandom_range(0, 7);
        py = (i == 0) ? wy : wy + $urandom_range(0, 7);
        video_on = (px < 640) && (py < 480);
        path_on = (i != 3);
        if (i == 2 && (mode == 2 || mode == 3)) path_on = 0;
        if (i == 4 && (mode == 1 || mode == 3)) goal_on = 1;
      end
      pix_x = 10'(px); pix_y = 10'(py);
      tick();
      reset = 0;
    end
  endtask

  initial begin
    reset = 1; pixel_tick = 0; video_on = 0; frame_tick = 0; path_on = 0; goal_on = 0;
    start = 0; pix_x = 0; pix_y = 0; cur_x = 0; cur_y = 0;
    tick();
    tick();
    reset = 0;
    for (int f = 0; f < 3000; f++) begin
      run_frame();
      if (miscompares > 20) break;
    end
    $display("coverage: play=%0d lose=%0d win=%0d done=%0d", n_play, n_lose, n_win, n_done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
